// File: rtl/pcs_pkg.sv
// Shared definitions for the 10GBASE-R receive PCS: sync header codes,
// block-lock state encoding and default window sizes.
package pcs_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam int SH_CNT_MAX_DEF   = 64;
  localparam int SH_INVLD_MAX_DEF = 16;

  typedef enum logic [1:0] {
    LOCK_INIT = 2'd0,
    TEST      = 2'd1,
    SLIP      = 2'd2,
    SLIP_HOLD = 2'd3
  } lock_state_e;

endpackage

// File: rtl/pcs_10g_block_lock.sv
// Clause-49 style block-lock controller: hunts for 66-bit block boundaries by
// slipping the RX gearbox one bit at a time, then polices header quality.
module pcs_10g_block_lock
  import pcs_pkg::*;
#(
  parameter int SH_CNT_MAX   = SH_CNT_MAX_DEF,
  parameter int SH_INVLD_MAX = SH_INVLD_MAX_DEF,
  parameter int SLIP_WAIT    = 2,
  parameter int SLIP_CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  signal_ok_i,
  input  logic                  valid_i,
  input  logic [1:0]            head_i,
  output logic                  slip_o,
  output logic                  block_lock_o,
  output logic [SLIP_CNT_W-1:0] slip_cnt_o
);

  localparam int CW = $clog2(SH_CNT_MAX + 1);
  localparam int IW = $clog2(SH_INVLD_MAX + 1);
  localparam int HW = 4;

  localparam logic [CW-1:0] CNT_MAX   = CW'(SH_CNT_MAX);
  localparam logic [IW-1:0] INVLD_MAX = IW'(SH_INVLD_MAX);
  localparam logic [HW-1:0] WAIT_C    = HW'(SLIP_WAIT);

  lock_state_e           state, state_n;
  logic [CW-1:0]         sh_cnt, sh_cnt_n, sh_cnt_inc;
  logic [IW-1:0]         sh_invld_cnt, invld_n, invld_inc;
  logic [HW-1:0]         hold_cnt, hold_n;
  logic                  lock_n, slip_n, go_slip, sh_valid;
  logic [SLIP_CNT_W-1:0] slip_cnt_n;

  assign sh_valid   = (head_i == SYNC_DATA) || (head_i == SYNC_CTRL);
  assign sh_cnt_inc = sh_cnt + 1'b1;
  assign invld_inc  = sh_invld_cnt + {{(IW-1){1'b0}}, ~sh_valid};

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state        <= LOCK_INIT;
      sh_cnt       <= '0;
      sh_invld_cnt <= '0;
      hold_cnt     <= '0;
      block_lock_o <= 1'b0;
      slip_o       <= 1'b0;
      slip_cnt_o   <= '0;
    end else begin
      state        <= state_n;
      sh_cnt       <= sh_cnt_n;
      sh_invld_cnt <= invld_n;
      hold_cnt     <= hold_n;
      block_lock_o <= lock_n;
      slip_o       <= slip_n;
      slip_cnt_o   <= slip_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    sh_cnt_n   = sh_cnt;
    invld_n    = sh_invld_cnt;
    hold_n     = hold_cnt;
    lock_n     = block_lock_o;
    slip_n     = 1'b0;
    slip_cnt_n = slip_cnt_o;
    go_slip    = 1'b0;

    if (!signal_ok_i) begin
      state_n    = LOCK_INIT;
      sh_cnt_n   = '0;
      invld_n    = '0;
      hold_n     = '0;
      lock_n     = 1'b0;
      slip_cnt_n = '0;
    end else begin
      case (state)
        LOCK_INIT: begin
          sh_cnt_n = '0;
          invld_n  = '0;
          lock_n   = 1'b0;
          state_n  = TEST;
        end
        TEST: if (valid_i) begin
          sh_cnt_n = sh_cnt_inc;
          invld_n  = invld_inc;
          if (block_lock_o) begin
            // loss of lock wins over a window end on the same header
            if (invld_inc == INVLD_MAX) begin
              lock_n  = 1'b0;
              go_slip = 1'b1;
            end else if (sh_cnt_inc == CNT_MAX) begin
              sh_cnt_n = '0;
              invld_n  = '0;
            end
          end else if (!sh_valid) begin
            go_slip = 1'b1;
          end else if (sh_cnt_inc == CNT_MAX) begin
            lock_n   = 1'b1;
            sh_cnt_n = '0;
            invld_n  = '0;
          end
        end
        SLIP: begin
          sh_cnt_n = '0;
          invld_n  = '0;
          hold_n   = '0;
          state_n  = (SLIP_WAIT == 0) ? TEST : SLIP_HOLD;
        end
        SLIP_HOLD: if (valid_i) begin
          // headers here are still misaligned by the gearbox shift
          hold_n = hold_cnt + 1'b1;
          if (hold_n == WAIT_C) state_n = TEST;
        end
        default: state_n = LOCK_INIT;
      endcase

      if (go_slip) begin
        state_n  = SLIP;
        slip_n   = 1'b1;
        sh_cnt_n = '0;
        invld_n  = '0;
        if (slip_cnt_o != '1) slip_cnt_n = slip_cnt_o + 1'b1;
      end
    end
  end

endmodule
